// File: rtl/mux_nx1_rr.sv
// N-to-1 streaming channel merge with a registered output stage, fixed-select or round-robin grant.
// Optional packet lock (in_last, grant held until the final beat) is built when MUX_NX1_LOCK_EN is defined.
module mux_nx1_rr #(
   parameter int N = 8,
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*W-1:0]       in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
`ifdef MUX_NX1_LOCK_EN
   input  logic [N-1:0]         in_last,
`endif
   input  logic                 mode,
   input  logic [$clog2(N)-1:0] sel,
   output logic [W-1:0]         out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [$clog2(N)-1:0] out_sel
);

   localparam int SW = $clog2(N);
   localparam logic [SW:0] N_EXT = (SW+1)'(N);

   logic [W-1:0]  ch_data [N];
   logic [SW-1:0] ptr;
   logic [SW-1:0] grant;
   logic [SW-1:0] ptr_next;
   logic [SW:0]   rr_sum;
   logic          grant_vld;
   logic          can_load;
   logic          xfer;

`ifdef MUX_NX1_LOCK_EN
   logic          locked;
   logic [SW-1:0] lock_ch;
`endif

   for (genvar k = 0; k < N; k++) begin : g_ch
      assign ch_data[k] = in_data[k*W +: W];
   end

   // Walking from the highest offset down leaves the first valid channel at or after ptr as the winner.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      rr_sum    = '0;
      if (!mode) begin
         if ({1'b0, sel} < N_EXT) begin
            grant     = sel;
            grant_vld = in_valid[sel];
         end
`ifdef MUX_NX1_LOCK_EN
      end else if (locked) begin
         grant     = lock_ch;
         grant_vld = in_valid[lock_ch];
`endif
      end else begin
         for (int i = N-1; i >= 0; i--) begin
            rr_sum = {1'b0, ptr} + (SW+1)'(i);
            if (rr_sum >= N_EXT) begin
               rr_sum = rr_sum - N_EXT;
            end
            if (in_valid[rr_sum[SW-1:0]]) begin
               grant     = rr_sum[SW-1:0];
               grant_vld = 1'b1;
            end
         end
      end
   end

   assign can_load = !out_valid || out_ready;
   assign xfer     = grant_vld && can_load && !rst;
   assign ptr_next = (grant == SW'(N-1)) ? '0 : grant + 1'b1;

   always_comb begin
      in_ready = '0;
      if (xfer) begin
         in_ready[grant] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
`ifdef MUX_NX1_LOCK_EN
         locked    <= 1'b0;
         lock_ch   <= '0;
`endif
      end else begin
         if (xfer) begin
            out_data  <= ch_data[grant];
            out_sel   <= grant;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (xfer && mode) begin
`ifdef MUX_NX1_LOCK_EN
            // The pointer only moves past a channel once its whole packet has gone through.
            if (in_last[grant]) begin
               locked <= 1'b0;
               ptr    <= ptr_next;
            end else begin
               locked  <= 1'b1;
               lock_ch <= grant;
            end
`else
            ptr <= ptr_next;
`endif
         end
`ifdef MUX_NX1_LOCK_EN
         if (!mode) begin
            locked <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Scoreboard bench for mux_nx1_rr (N=10): directed stimulus pushes expected beats, a monitor pops on each output handshake.
module tb_mux_nx1_rr;

   localparam int N  = 10;
   localparam int W  = 8;
   localparam int SW = $clog2(N);

   logic           clk;
   logic           rst;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [N-1:0]   in_last;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic [SW-1:0]  out_sel;

   typedef struct {
      logic [W-1:0]  d;
      logic [SW-1:0] s;
   } beat_t;

   beat_t exp_q[$];
   beat_t mon_b;
   int    n_vec = 0;
   int    n_err = 0;

   mux_nx1_rr #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef MUX_NX1_LOCK_EN
      .in_last   (in_last),
`endif
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sel   (out_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input int ch);
      beat_t b;
      b.d = W'(ch * 17);
      b.s = SW'(ch);
      exp_q.push_back(b);
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got sel %0d data %0h, required no beat", out_sel, out_data);
         end else begin
            mon_b = exp_q.pop_front();
            check("beat_data", 32'(out_data), 32'(mon_b.d));
            check("beat_sel", 32'(out_sel), 32'(mon_b.s));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time expired, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 10'h0FF;
      in_last   = '0;
      out_ready = 1'b1;
      mode      = 1'b0;
      sel       = '0;
      for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(k * 17);

      // reset held with traffic pending
      next_cyc();
      repeat (2) begin
         @(negedge clk);
         check("rst_out_valid", 32'(out_valid), 0);
         check("rst_out_sel", 32'(out_sel), 0);
         check("rst_in_ready", 32'(in_ready), 0);
         next_cyc();
      end
      rst = 1'b0;
      push_exp(0);
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'h001);
      check("post_rst_out_valid", 32'(out_valid), 0);
      next_cyc();
      in_valid = '0;
      @(negedge clk);
      check("first_out_valid", 32'(out_valid), 1);
      next_cyc();

      // fixed select
      sel = 4'd5;
      in_valid = 10'h0FF;
      push_exp(5);
      @(negedge clk);
      check("fixed_in_ready", 32'(in_ready), 32'h020);
      next_cyc();
      sel = 4'd9;
      @(negedge clk);
      check("fixed_out_data", 32'(out_data), 32'h55);
      check("sel9_in_ready", 32'(in_ready), 0);
      next_cyc();
      @(negedge clk);
      check("sel9_drained", 32'(out_valid), 0);
      next_cyc();
      sel = 4'd12;
      @(negedge clk);
      check("sel12_in_ready", 32'(in_ready), 0);
      next_cyc();

      // round-robin, all low eight channels valid
      mode = 1'b1;
      for (int i = 0; i < 10; i++) push_exp(i % 8);
      for (int i = 0; i < 10; i++) begin
         next_cyc();
         if (i == 9) in_valid = '0;
         @(negedge clk);
         check("rr_full_valid", 32'(out_valid), 1);
         check("rr_full_sel", 32'(out_sel), 32'(i % 8));
      end
      next_cyc();

      // re-reset, then sparse wrap-around
      rst = 1'b1;
      in_valid = 10'h0FF;
      @(negedge clk);
      check("rst_rr_in_ready", 32'(in_ready), 0);
      next_cyc();
      rst = 1'b0;
      in_valid = 10'b00_1000_0100;
      push_exp(2); push_exp(7); push_exp(2); push_exp(7);
      for (int i = 0; i < 4; i++) begin
         next_cyc();
         if (i == 3) in_valid = '0;
         @(negedge clk);
         check("rr_sparse_valid", 32'(out_valid), 1);
         check("rr_sparse_sel", 32'(out_sel), (i % 2 == 0) ? 2 : 7);
      end
      next_cyc();

      // backpressure then no-bubble reload
      mode = 1'b0;
      sel = 4'd3;
      in_valid = 10'h0FF;
      out_ready = 1'b0;
      push_exp(3);
      next_cyc();
      sel = 4'd6;
      repeat (5) begin
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 1);
         check("bp_out_data", 32'(out_data), 32'h33);
         check("bp_out_sel", 32'(out_sel), 3);
         check("bp_in_ready", 32'(in_ready), 0);
         next_cyc();
      end
      out_ready = 1'b1;
      push_exp(6);
      @(negedge clk);
      check("reload_in_ready", 32'(in_ready), 32'h040);
      next_cyc();
      in_valid = '0;
      @(negedge clk);
      check("reload_valid", 32'(out_valid), 1);
      check("reload_sel", 32'(out_sel), 6);
      next_cyc();

      // reset drops a held beat
      out_ready = 1'b0;
      sel = 4'd2;
      in_valid = 10'h004;
      next_cyc();
      in_valid = '0;
      @(negedge clk);
      check("held_valid", 32'(out_valid), 1);
      next_cyc();
      rst = 1'b1;
      in_valid = 10'h0FF;
      @(negedge clk);
      check("mid_rst_in_ready", 32'(in_ready), 0);
      next_cyc();
      rst = 1'b0;
      in_valid = '0;
      out_ready = 1'b1;
      @(negedge clk);
      check("dropped_valid", 32'(out_valid), 0);
      check("dropped_data", 32'(out_data), 0);
      check("dropped_sel", 32'(out_sel), 0);

`ifdef MUX_NX1_LOCK_EN
      // packet lock on channel 3 while channel 0 waits
      next_cyc();
      mode = 1'b1;
      in_valid = 10'h008;
      in_last = '0;
      push_exp(3); push_exp(3); push_exp(3); push_exp(3); push_exp(0);
      next_cyc();
      in_valid = 10'h009;
      @(negedge clk);
      check("lock_in_ready_b2", 32'(in_ready), 32'h008);
      next_cyc();
      @(negedge clk);
      check("lock_in_ready_b3", 32'(in_ready), 32'h008);
      next_cyc();
      in_valid = 10'h001;
      @(negedge clk);
      check("lock_gap_in_ready", 32'(in_ready), 0);
      next_cyc();
      @(negedge clk);
      check("lock_gap_out_valid", 32'(out_valid), 0);
      check("lock_gap_in_ready2", 32'(in_ready), 0);
      next_cyc();
      in_valid = 10'h009;
      in_last = 10'h008;
      @(negedge clk);
      check("lock_last_in_ready", 32'(in_ready), 32'h008);
      next_cyc();
      in_last = '0;
      @(negedge clk);
      check("unlock_in_ready", 32'(in_ready), 32'h001);
      next_cyc();
      in_valid = '0;
      @(negedge clk);
      check("unlock_sel", 32'(out_sel), 0);
`endif

      next_cyc();
      repeat (2) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-to-1 streaming multiplexer with registered output, valid/ready handshakes on every channel, and two selection modes: fixed external select and round-robin arbitration. It generalises the team's combinational 8x1 mux into a pipelined channel-merge stage. It sits wherever several producers share one downstream consumer, for example merging peripheral data streams onto a single bus.

## Interface
- N, default 8: number of input channels, ≥2, need not be a power of two.
- W, default 8: data width per channel, ≥1.
- SW, localparam: select width, `$clog2(N)`.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N*W  channel k occupies bits [k*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; at most one bit is high.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SW  channel index used when mode=0.
- out_data  out  W  registered selected data.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accepts the beat.
- out_sel  out  SW  index of the channel that supplied out_data.
- in_last  in  N  present only with MUX_NX1_LOCK_EN; marks the final beat of a packet.

## Operation
- Output register: a single stage holding out_data, out_sel and out_valid.
- can_load = !out_valid | out_ready.
- Grant g is combinational from in_valid, mode, sel and the pointer ptr.
  - mode=0: g = sel if in_valid[sel]. No grant if in_valid[sel]=0 or sel ≥ N.
  - mode=1: g is the first k with in_valid[k] set, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap-around).
- in_ready[g] = can_load when a grant exists; all other in_ready bits are 0. in_ready never depends on the channel's own in_valid beyond the grant decision.
- Transfer on channel g when in_valid[g] & in_ready[g]:
  - out_data ← channel g data, out_sel ← g, out_valid ← 1.
  - In mode=1, ptr ← (g+1) mod N.
- Output handshake: out_valid & out_ready with no new transfer clears out_valid. out_data and out_sel hold their last value.
- ptr updates only on mode=1 transfers. Changing mode or sel takes effect at the next arbitration, and an in-flight output beat is unaffected.
- While out_valid=1 and out_ready=0, out_data, out_sel and out_valid are stable and all in_ready bits are 0.

## Timing
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_sel=0, ptr=0, lock state cleared. in_ready=0 while rst is high.
- Reset mid-transfer drops the held beat without emitting it.
- Latency: input transfer at edge t gives out_valid=1 after edge t.
- Throughput: one beat per cycle when out_ready stays high. Simultaneous output drain and input load in the same cycle is a full-throughput reload with no bubble.
- Fixed-mode and round-robin decisions complete in the same cycle as the transfer. There is no extra arbitration cycle.

## Configuration
- MUX_NX1_LOCK_EN defined:
  - in_last port exists.
  - In mode=1, once channel g transfers a beat with in_last[g]=0, the grant is locked to g until a beat with in_last[g]=1 transfers.
  - ptr advances only on that last beat.
  - If in_valid[g] drops while locked, no other channel is granted.
  - Reset or a mode change to 0 clears the lock.
- MUX_NX1_LOCK_EN undefined: no in_last port. Every beat is arbitrated independently.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=8'hFF and out_ready=1 → out_valid=0, out_sel=0, in_ready=0 throughout; first out_valid=1 appears one cycle after rst falls.
- Fixed mode: mode=0, sel=5, in_valid=8'hFF, channel k data = k*8'h11 → in_ready=8'h20, next cycle out_data=8'h55 and out_sel=5. Then sel=9 with N=10 → no grant, out_valid falls after drain.
- Round-robin full: mode=1, in_valid=8'hFF, out_ready=1 for 10 cycles → out_sel sequence 0,1,2,3,4,5,6,7,0,1 with out_valid high every cycle.
- Round-robin sparse/wrap: in_valid=8'b1000_0100 from reset → out_sel 2,7,2,7 in consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 → out_data and out_sel stable, in_ready=0. Raise out_ready → the next beat loads in that same cycle with no bubble.
- Lock (MUX_NX1_LOCK_EN): ch3 sends 4 beats with in_last on the 4th while ch0 is continuously valid → out_sel 3,3,3,3,0. Deassert in_valid[3] for 2 cycles mid-packet → out_valid drops and ch0 is not granted.
